next_pc_ctrl: RTL and testbench
===============================

// Module: next_pc_ctrl
// PURPOSE
//  Next-PC select generator with branch prediction, successor to the fetch-only JAL/JALR select decoder.
//  Predicts conditional branches at fetch (static or 2-bit BHT mode), resolves JALR and branches at EX.
//  Drives the PC mux select and a multi-cycle wrong-path flush; keeps branch/mispredict counters.
//  Sits between the icache output, the PC register/adders and the EX-stage branch compare.
// PARAMETERS
//  XLEN         32  PC width.
//  BHT_DEPTH    64  BHT entries (power of 2); IDX_W = $clog2(BHT_DEPTH).
//  PREDICT_MODE 1   0 = static not-taken, 1 = 2-bit BHT, 2 = BTFN (backward taken).
//  FLUSH_CYCLES 2   Wrong-path cycles between fetch and EX (>=1).
//  CNT_W        32  Performance counter width.
// PORTS
//  clk              in   1      Clock.
//  rst              in   1      Asynchronous reset, active-high.
//  icache_dout      in   32     Instruction at fetch.
//  fetch_pc         in   XLEN   PC of icache_dout.
//  fetch_valid      in   1      icache_dout holds a real instruction.
//  ex_valid         in   1      EX holds a real instruction.
//  ex_pc            in   XLEN   PC of the EX instruction.
//  ex_is_branch     in   1      EX is OPC_BRANCH.
//  ex_is_jalr       in   1      EX is OPC_JALR.
//  ex_taken         in   1      Resolved branch outcome.
//  ex_pred_taken    in   1      Prediction carried down the pipe with the EX instruction.
//  pc_sel           out  2      00 pc+4, 01 fetch_pc+imm, 10 rs1+imm (EX), 11 EX branch correction.
//  pred_taken       out  1      Fetch prediction; pipelined alongside the instruction.
//  flush            out  1      Kill wrong-path instructions in IF..EX.
//  branch_cnt       out  CNT_W  Resolved conditional branches.
//  mispred_cnt      out  CNT_W  Mispredicted conditional branches.
// BEHAVIOUR
//  - Reset: all BHT entries 2'b01 (weakly not-taken), flush_cnt 0, counters 0.
//    pc_sel, pred_taken and flush are combinational; with no valid inputs they are 00, 0, 0.
//  - ex_ok = ex_valid & (flush_cnt == 0); EX inputs are ignored while flush_cnt != 0.
//  - Fetch (combinational, same cycle), fetch_valid=1:
//    - OPC_JAL: pc_sel=01, pred_taken=1.
//    - OPC_BRANCH: pred_taken per mode: 0 -> 0; 1 -> BHT[fetch_pc[IDX_W+1:2]][1]; 2 -> icache_dout[31].
//      pc_sel = pred_taken ? 01 : 00.
//    - OPC_JALR and all others: pc_sel=00, pred_taken=0.
//  - EX redirect (overrides fetch; same cycle):
//    - ex_ok & ex_is_jalr -> pc_sel=10.
//    - ex_ok & ex_is_branch & (ex_taken != ex_pred_taken) -> pc_sel=11.
//  - Flush:
//    - flush = redirect | (flush_cnt != 0).
//    - On redirect, flush_cnt <= FLUSH_CYCLES-1; otherwise it decrements to 0.
//    - With FLUSH_CYCLES=1, flush is high only in the redirect cycle.
//  - BHT update (posedge), on ex_ok & ex_is_branch, entry ex_pc[IDX_W+1:2]:
//    - taken: +1, saturating at 11; not taken: -1, saturating at 00.
//    - Update happens in modes 0 and 2 too; the result is unused there.
//  - BHT read is asynchronous. If fetch reads the entry EX writes in the same cycle, fetch sees the
//    old value (no bypass).
//  - Counters: ex_ok & ex_is_branch increments branch_cnt; a mispredict also increments mispred_cnt.
//    Both saturate at all-ones.
//  - rst asserted mid-operation clears flush_cnt immediately; flush drops in that cycle (absent
//    redirect inputs).
// STRUCTURE
//  - Opcode constants (OPC_JAL, OPC_JALR, OPC_BRANCH) come from the shared Opcode.vh.
//  - Add the PC_SEL_* encodings and PRED_* mode constants to a shared header, PCSel.vh.
//  - One sub-module: bht_table. It holds the DEPTH x 2-bit array, has an async read port and a
//    saturating-update write port, and is instantiated only when PREDICT_MODE==1 (generate).
// TESTING
//  1. Reset, then JAL at fetch_pc=0x100 -> pc_sel=01, pred_taken=1, flush=0.
//  2. Mode 1: branch at 0x200 resolves taken twice (ex_pred_taken=0).
//     -> Each EX cycle gives pc_sel=11 and flush high for FLUSH_CYCLES cycles.
//     -> After that, a fetch at 0x200 gives pred_taken=1, pc_sel=01.
//     -> Counters read branch_cnt=2, mispred_cnt=2.
//  3. ex_is_jalr with fetch JAL in the same cycle -> pc_sel=10 (EX wins), flush=1.
//     -> A second redirect presented during flush_cnt!=0 is ignored; no counter change.
//  4. Mode 2: branch with icache_dout[31]=1 -> pred_taken=1.
//     -> Same branch with bit31=0 -> pred_taken=0.
//  5. Same-cycle fetch read and EX update of BHT index 5 (entry 01, taken).
//     -> Fetch predicts 0; the next cycle's fetch predicts 1 (entry 10).
//  6. Assert rst while flush_cnt=1 -> flush=0 immediately; BHT returns to 01; counters read 0.

Source files
------------

// File: rtl/next_pc_ctrl_pkg.sv
// Shared constants for the next-PC select path: opcode values, PC mux encodings,
// prediction modes and the 2-bit branch history counter states.
package next_pc_ctrl_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] PC_SEL_PC4    = 2'b00;
    localparam logic [1:0] PC_SEL_JAL    = 2'b01;
    localparam logic [1:0] PC_SEL_JALR   = 2'b10;
    localparam logic [1:0] PC_SEL_BR_FIX = 2'b11;

    localparam int PRED_STATIC = 0;
    localparam int PRED_BHT    = 1;
    localparam int PRED_BTFN   = 2;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } bht_ctr_e;

endpackage

// File: rtl/next_pc_ctrl_bht_table.sv
// Branch history table: DEPTH x 2-bit saturating counters, asynchronous read,
// one update port. A same-cycle read of the entry being written returns the old value.
module next_pc_ctrl_bht_table
    import next_pc_ctrl_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    logic [1:0] r_ctr [DEPTH];

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? c : c + 2'd1;
        else
            return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_ctr[i] <= CTR_WNT;
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= sat_step(r_ctr[i_wr_idx], i_wr_taken);
        end
    end

    assign o_rd_ctr = r_ctr[i_rd_idx];

endmodule

// File: rtl/next_pc_ctrl.sv
// Next-PC select: fetch-time JAL/branch prediction, EX-time JALR and branch-correction
// redirects, multi-cycle wrong-path flush and branch/mispredict counters.
module next_pc_ctrl
    import next_pc_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_DEPTH    = 64,
    parameter int PREDICT_MODE = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      icache_dout,
    input  logic [XLEN-1:0]  fetch_pc,
    input  logic             fetch_valid,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_is_branch,
    input  logic             ex_is_jalr,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    output logic [1:0]       pc_sel,
    output logic             pred_taken,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

    logic [FC_W-1:0]  r_flush_cnt;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic [6:0] w_opc;
    logic [1:0] w_bht_ctr;
    logic       w_br_pred;
    logic [1:0] w_fetch_sel;
    logic       w_fetch_pred;
    logic       w_ex_ok;
    logic       w_ex_br;
    logic       w_ex_mispred;
    logic       w_redir_jalr;
    logic       w_redir_br;
    logic       w_redirect;
    logic       w_unused;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // EX stage is trusted only once the previous redirect's wrong-path shadow has drained
    assign w_ex_ok      = ex_valid & (r_flush_cnt == '0);
    assign w_ex_br      = w_ex_ok & ex_is_branch;
    assign w_ex_mispred = ex_taken ^ ex_pred_taken;
    assign w_redir_jalr = w_ex_ok & ex_is_jalr;
    assign w_redir_br   = w_ex_br & w_ex_mispred;
    assign w_redirect   = w_redir_jalr | w_redir_br;

    generate
        if (PREDICT_MODE == PRED_BHT) begin : g_bht
            next_pc_ctrl_bht_table #(.DEPTH(BHT_DEPTH)) u_bht (
                .clk        (clk),
                .rst        (rst),
                .i_rd_idx   (fetch_pc[IDX_W+1:2]),
                .o_rd_ctr   (w_bht_ctr),
                .i_wr_en    (w_ex_br),
                .i_wr_idx   (ex_pc[IDX_W+1:2]),
                .i_wr_taken (ex_taken)
            );
        end else begin : g_no_bht
            assign w_bht_ctr = CTR_WNT;
        end
    endgenerate

    assign w_opc     = icache_dout[6:0];
    assign w_br_pred = (PREDICT_MODE == PRED_BHT)  ? w_bht_ctr[1]    :
                       (PREDICT_MODE == PRED_BTFN) ? icache_dout[31] : 1'b0;

    always_comb begin
        w_fetch_sel  = PC_SEL_PC4;
        w_fetch_pred = 1'b0;
        if (fetch_valid) begin
            if (w_opc == OPC_JAL) begin
                w_fetch_sel  = PC_SEL_JAL;
                w_fetch_pred = 1'b1;
            end else if (w_opc == OPC_BRANCH) begin
                w_fetch_pred = w_br_pred;
                w_fetch_sel  = w_br_pred ? PC_SEL_JAL : PC_SEL_PC4;
            end
        end
    end

    always_comb begin
        pc_sel = w_fetch_sel;
        if (w_redir_jalr)
            pc_sel = PC_SEL_JALR;
        else if (w_redir_br)
            pc_sel = PC_SEL_BR_FIX;
    end

    assign pred_taken = w_fetch_pred;
    assign flush      = w_redirect | (r_flush_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_flush_cnt <= '0;
        else if (w_redirect)
            r_flush_cnt <= FC_LOAD;
        else if (r_flush_cnt != '0)
            r_flush_cnt <= r_flush_cnt - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_ex_br) begin
            r_branch_cnt <= sat_inc(r_branch_cnt);
            if (w_ex_mispred)
                r_mispred_cnt <= sat_inc(r_mispred_cnt);
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

    // Only the index bits of the PCs and a few instruction bits matter here
    assign w_unused = ^{fetch_pc, ex_pc, icache_dout, w_bht_ctr};

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Bench for next_pc_ctrl: a BHT-mode and a BTFN-mode instance share one stimulus stream and
// are compared with a counter-array reference model, plus table vectors and directed sequences.
module tb_next_pc_ctrl;

    localparam int F = 2;
    localparam logic [31:0] I_JAL    = 32'h0000006F;
    localparam logic [31:0] I_JALR   = 32'h00000067;
    localparam logic [31:0] I_BR     = 32'h00000063;
    localparam logic [31:0] I_BR_NEG = 32'h80000063;
    localparam logic [31:0] I_ADDI   = 32'h00000013;

    logic        clk;
    logic        rst;
    logic [31:0] icache_dout;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jalr;
    logic        ex_taken;
    logic        ex_pred_taken;

    logic [1:0]  sel1, sel2;
    logic        pt1, pt2, fl1, fl2;
    logic [31:0] bc1, mc1, bc2, mc2;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    int          m_bht [64];
    int          m_fcnt;
    logic [31:0] m_bc, m_mc;

    next_pc_ctrl #(.XLEN(32), .BHT_DEPTH(64), .PREDICT_MODE(1), .FLUSH_CYCLES(F), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst), .icache_dout(icache_dout), .fetch_pc(fetch_pc),
        .fetch_valid(fetch_valid), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_is_branch(ex_is_branch), .ex_is_jalr(ex_is_jalr), .ex_taken(ex_taken),
        .ex_pred_taken(ex_pred_taken), .pc_sel(sel1), .pred_taken(pt1), .flush(fl1),
        .branch_cnt(bc1), .mispred_cnt(mc1)
    );

    next_pc_ctrl #(.XLEN(32), .BHT_DEPTH(64), .PREDICT_MODE(2), .FLUSH_CYCLES(F), .CNT_W(32)) dut2 (
        .clk(clk), .rst(rst), .icache_dout(icache_dout), .fetch_pc(fetch_pc),
        .fetch_valid(fetch_valid), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_is_branch(ex_is_branch), .ex_is_jalr(ex_is_jalr), .ex_taken(ex_taken),
        .ex_pred_taken(ex_pred_taken), .pc_sel(sel2), .pred_taken(pt2), .flush(fl2),
        .branch_cnt(bc2), .mispred_cnt(mc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        fv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  e_sel1;
        logic        e_pt1;
        logic [1:0]  e_sel2;
        logic        e_pt2;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        m_fcnt = 0;
        m_bc   = '0;
        m_mc   = '0;
    endfunction

    function automatic bit model_redirect();
        bit ok;
        ok = ex_valid && (m_fcnt == 0);
        return ok && (ex_is_jalr || (ex_is_branch && (ex_taken != ex_pred_taken)));
    endfunction

    function automatic void model_exp(input int mode, output logic [1:0] sel, output logic pt,
                                      output logic fl);
        bit ok;
        sel = 2'd0;
        pt  = 1'b0;
        ok  = ex_valid && (m_fcnt == 0);
        if (fetch_valid) begin
            if (icache_dout[6:0] == I_JAL[6:0]) begin
                sel = 2'd1;
                pt  = 1'b1;
            end else if (icache_dout[6:0] == I_BR[6:0]) begin
                if (mode == 1)      pt = (m_bht[fetch_pc[7:2]] >= 2);
                else if (mode == 2) pt = icache_dout[31];
                sel = pt ? 2'd1 : 2'd0;
            end
        end
        if (ok && ex_is_jalr)
            sel = 2'd2;
        else if (ok && ex_is_branch && (ex_taken != ex_pred_taken))
            sel = 2'd3;
        fl = model_redirect() || (m_fcnt != 0);
    endfunction

    function automatic void model_step();
        bit ok, redir;
        int idx;
        ok    = ex_valid && (m_fcnt == 0);
        redir = model_redirect();
        if (ok && ex_is_branch) begin
            idx = int'(ex_pc[7:2]);
            if (ex_taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else          m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
            if (m_bc != 32'hFFFFFFFF) m_bc = m_bc + 1;
            if (ex_taken != ex_pred_taken && m_mc != 32'hFFFFFFFF) m_mc = m_mc + 1;
        end
        if (redir)           m_fcnt = F - 1;
        else if (m_fcnt > 0) m_fcnt = m_fcnt - 1;
    endfunction

    // checks both instances against the model at the falling edge, then advances one clock
    task automatic cycle();
        logic [1:0] s;
        logic p, f;
        @(negedge clk);
        model_exp(1, s, p, f);
        chk("m1 pc_sel", 32'(sel1), 32'(s));
        chk("m1 pred_taken", 32'(pt1), 32'(p));
        chk("m1 flush", 32'(fl1), 32'(f));
        chk("m1 branch_cnt", bc1, m_bc);
        chk("m1 mispred_cnt", mc1, m_mc);
        model_exp(2, s, p, f);
        chk("m2 pc_sel", 32'(sel2), 32'(s));
        chk("m2 pred_taken", 32'(pt2), 32'(p));
        chk("m2 flush", 32'(fl2), 32'(f));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        icache_dout   = 32'h0;
        fetch_pc      = 32'h0;
        fetch_valid   = 1'b0;
        ex_valid      = 1'b0;
        ex_pc         = 32'h0;
        ex_is_branch  = 1'b0;
        ex_is_jalr    = 1'b0;
        ex_taken      = 1'b0;
        ex_pred_taken = 1'b0;
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic br, input logic jalr,
                          input logic tk, input logic ptk);
        ex_valid      = 1'b1;
        ex_pc         = pc;
        ex_is_branch  = br;
        ex_is_jalr    = jalr;
        ex_taken      = tk;
        ex_pred_taken = ptk;
    endtask

    task automatic set_fetch(input logic [31:0] pc, input logic [31:0] instr);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        icache_dout = instr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset pc_sel", 32'(sel1), 32'd0);
        chk("reset pred_taken", 32'(pt1), 32'd0);
        chk("reset flush", 32'(fl1), 32'd0);
        chk("reset branch_cnt", bc1, 32'd0);
        chk("reset mispred_cnt", mc1, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();

        vecs[0] = '{1'b0, I_JAL,    32'h100, 2'd0, 1'b0, 2'd0, 1'b0};
        vecs[1] = '{1'b1, I_JAL,    32'h100, 2'd1, 1'b1, 2'd1, 1'b1};
        vecs[2] = '{1'b1, I_BR_NEG, 32'h040, 2'd0, 1'b0, 2'd1, 1'b1};
        vecs[3] = '{1'b1, I_BR,     32'h040, 2'd0, 1'b0, 2'd0, 1'b0};
        vecs[4] = '{1'b1, I_JALR,   32'h080, 2'd0, 1'b0, 2'd0, 1'b0};
        vecs[5] = '{1'b1, I_ADDI,   32'h084, 2'd0, 1'b0, 2'd0, 1'b0};

        do_reset();

        for (int i = 0; i < 6; i++) begin
            fetch_valid = vecs[i].fv;
            icache_dout = vecs[i].instr;
            fetch_pc    = vecs[i].pc;
            #1;
            chk($sformatf("vec%0d m1 pc_sel", i), 32'(sel1), 32'(vecs[i].e_sel1));
            chk($sformatf("vec%0d m1 pred", i), 32'(pt1), 32'(vecs[i].e_pt1));
            chk($sformatf("vec%0d m2 pc_sel", i), 32'(sel2), 32'(vecs[i].e_sel2));
            chk($sformatf("vec%0d m2 pred", i), 32'(pt2), 32'(vecs[i].e_pt2));
            chk($sformatf("vec%0d flush", i), 32'(fl1), 32'd0);
            cycle();
        end
        clear_inputs();

        // branch at 0x200 resolves taken twice while predicted not-taken
        for (int k = 0; k < 2; k++) begin
            set_ex(32'h200, 1'b1, 1'b0, 1'b1, 1'b0);
            #1;
            chk("t2 redirect pc_sel", 32'(sel1), 32'd3);
            chk("t2 redirect flush", 32'(fl1), 32'd1);
            cycle();
            clear_inputs();
            #1;
            chk("t2 flush hold", 32'(fl1), 32'd1);
            cycle();
            #1;
            chk("t2 flush end", 32'(fl1), 32'd0);
        end
        set_fetch(32'h200, I_BR);
        #1;
        chk("t2 trained pred", 32'(pt1), 32'd1);
        chk("t2 trained pc_sel", 32'(sel1), 32'd1);
        chk("t2 branch_cnt", bc1, 32'd2);
        chk("t2 mispred_cnt", mc1, 32'd2);
        cycle();
        clear_inputs();

        // JALR at EX overrides fetch JAL; a redirect during the flush shadow is ignored
        set_fetch(32'h300, I_JAL);
        set_ex(32'h280, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("t3 ex wins pc_sel", 32'(sel1), 32'd2);
        chk("t3 flush", 32'(fl1), 32'd1);
        cycle();
        fetch_valid = 1'b0;
        set_ex(32'h284, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("t3 ignored pc_sel", 32'(sel1), 32'd0);
        chk("t3 ignored flush", 32'(fl1), 32'd1);
        cycle();
        clear_inputs();
        #1;
        chk("t3 branch_cnt kept", bc1, 32'd2);
        chk("t3 mispred_cnt kept", mc1, 32'd2);
        cycle();

        // BTFN: sign bit of the branch immediate decides
        set_fetch(32'h400, I_BR_NEG);
        #1;
        chk("t4 btfn backward pred", 32'(pt2), 32'd1);
        chk("t4 btfn backward sel", 32'(sel2), 32'd1);
        cycle();
        icache_dout = I_BR;
        #1;
        chk("t4 btfn forward pred", 32'(pt2), 32'd0);
        chk("t4 btfn forward sel", 32'(sel2), 32'd0);
        cycle();
        clear_inputs();

        // same-cycle read and update of BHT index 5: fetch sees the old entry
        set_fetch(32'h14, I_BR);
        set_ex(32'h14, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        chk("t5 same-cycle pred", 32'(pt1), 32'd0);
        cycle();
        ex_valid = 1'b0;
        #1;
        chk("t5 next-cycle pred", 32'(pt1), 32'd1);
        cycle();
        clear_inputs();

        // asynchronous reset in the middle of a flush
        set_ex(32'h500, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        clear_inputs();
        set_fetch(32'h200, I_BR);
        #1;
        chk("t6 flush before rst", 32'(fl1), 32'd1);
        chk("t6 pred before rst", 32'(pt1), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6 flush after rst", 32'(fl1), 32'd0);
        chk("t6 bht after rst", 32'(pt1), 32'd0);
        chk("t6 branch_cnt after rst", bc1, 32'd0);
        chk("t6 mispred_cnt after rst", mc1, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

        // randomized traffic over a small PC set so BHT entries alias and saturate
        for (int n = 0; n < 600; n++) begin
            logic [31:0] opc;
            case ($urandom_range(0, 3))
                0:       opc = I_JAL;
                1:       opc = I_JALR;
                2:       opc = I_BR;
                default: opc = I_ADDI;
            endcase
            fetch_valid   = ($urandom_range(0, 9) < 8);
            icache_dout   = ($urandom & 32'hFFFFFF80) | opc;
            fetch_pc      = ($urandom & 32'hFFFFFF00) | (32'($urandom_range(0, 7)) << 2);
            ex_valid      = ($urandom_range(0, 9) < 7);
            ex_pc         = ($urandom & 32'hFFFFFF00) | (32'($urandom_range(0, 7)) << 2);
            ex_is_branch  = ($urandom_range(0, 1) == 1);
            ex_is_jalr    = ($urandom_range(0, 9) == 0);
            ex_taken      = ($urandom_range(0, 3) != 0);
            ex_pred_taken = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
